// File: rtl/ysyx_pkg.sv
// Shared constants and state encoding for the ysyx instruction fetch unit.
package ysyx_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } ifu_state_e;

  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: PC register, fetch FSM and one-entry output buffer.
// Define IFU_ALIGN_CHECK_EN to trap misaligned redirect targets instead of masking them.
module ysyx_ifu #(
  parameter logic [ysyx_pkg::XLEN-1:0] RESET_PC = ysyx_pkg::RESET_PC,
  parameter logic [ysyx_pkg::XLEN-1:0] NOP_INST = ysyx_pkg::NOP_INST
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [ysyx_pkg::XLEN-1:0] imem_req_addr,
  input  logic                      imem_rsp_valid,
  input  logic [ysyx_pkg::XLEN-1:0] imem_rsp_data,
  input  logic                      imem_rsp_err,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [ysyx_pkg::XLEN-1:0] inst,
  output logic [ysyx_pkg::XLEN-1:0] inst_pc,
  output logic                      inst_fault,
  input  logic                      redirect_valid,
  input  logic [ysyx_pkg::XLEN-1:0] redirect_pc
);
  import ysyx_pkg::*;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_fault_q, inst_fault_d;

  logic            pc_misaligned;
  logic            req_fire;
  logic [XLEN-1:0] redirect_target;

`ifdef IFU_ALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign pc_misaligned   = (pc_q[1:0] != 2'b00);
`else
  assign redirect_target = redirect_pc & ~32'h3;
  assign pc_misaligned   = 1'b0;
`endif

  // A misaligned PC never reaches memory; it is turned into a local fault instead.
  assign imem_req_valid = rst_n && (state_q == REQ) && !pc_misaligned;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    unique case (state_q)
      REQ: begin
        if (pc_misaligned) begin
          state_d      = HOLD;
          inst_valid_d = 1'b1;
          inst_d       = NOP_INST;
          inst_pc_d    = pc_q;
          inst_fault_d = 1'b1;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d      = HOLD;
          inst_valid_d = 1'b1;
          inst_d       = imem_rsp_err ? NOP_INST : imem_rsp_data;
          inst_pc_d    = pc_q;
          inst_fault_d = imem_rsp_err;
        end
      end
      HOLD: begin
        // A consumed misalignment fault leaves the unit parked here until a redirect.
        if (inst_valid_q && inst_ready) begin
          inst_valid_d = 1'b0;
          if (!pc_misaligned) begin
            pc_d    = pc_incr(pc_q);
            state_d = REQ;
          end
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
    endcase

    if (redirect_valid) begin
      pc_d         = redirect_target;
      inst_valid_d = 1'b0;
      unique case (state_q)
        REQ:  state_d = req_fire ? DROP : REQ;
        WAIT: state_d = imem_rsp_valid ? REQ : DROP;
        HOLD: state_d = REQ;
        // The squashed response may land in the same cycle; it is consumed either way.
        DROP: state_d = imem_rsp_valid ? REQ : DROP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Directed bench for ysyx_ifu with a small latency-programmable instruction memory model.
module tb_ysyx_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory model: word at addr is 0x00100093 + (word index from 0x80000000) << 20.
  logic        ready_en = 1'b1;
  int          lat = 0;
  int          fire_cnt = 0;
  logic        fire_next = 1'b0;
  logic [31:0] fire_addr = 32'h0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + (((a - 32'h8000_0000) >> 2) << 20);
  endfunction

  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    if (!rst_n) begin
      pend      = 1'b0;
      fire_next = 1'b0;
    end else begin
      if (fire_next) begin
        pend     = 1'b1;
        cnt      = lat;
        paddr    = fire_addr;
        fire_cnt = fire_cnt + 1;
      end
      fire_next = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
          imem_rsp_err   = (paddr == 32'h8000_0008);
          pend           = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
    end
    imem_req_ready = ready_en;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      fire_next = 1'b1;
      fire_addr = imem_req_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_valid, input logic [31:0] e_inst,
                         input logic [31:0] e_pc, input logic e_fault,
                         input logic e_req, input logic [31:0] e_addr);
    chk({tag, ".inst_valid"}, {31'h0, inst_valid}, {31'h0, e_valid});
    chk({tag, ".req_valid"}, {31'h0, imem_req_valid}, {31'h0, e_req});
    if (e_valid) begin
      chk({tag, ".inst"}, inst, e_inst);
      chk({tag, ".inst_pc"}, inst_pc, e_pc);
      chk({tag, ".inst_fault"}, {31'h0, inst_fault}, {31'h0, e_fault});
    end
    if (e_req) chk({tag, ".req_addr"}, imem_req_addr, e_addr);
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_fault;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[12];
  int   f0;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 32'h8000_0004};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0020_0093, 32'h8000_0004, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 32'h8000_0008};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0013, 32'h8000_0008, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 32'h8000_0200};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0810_0093, 32'h8000_0200, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0,          1'b0, 1'b1, 32'h8000_0204};

    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();
    chk("rst.req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst.inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst.inst", inst, 32'h0000_0013);
    chk("rst.inst_pc", inst_pc, 32'h8000_0000);
    chk("rst.inst_fault", {31'h0, inst_fault}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk_out("rel", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0000);

    for (int i = 0; i < 12; i++) begin
      inst_ready     = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc,
              vecs[i].e_fault, vecs[i].e_req, vecs[i].e_addr);
    end
    redirect_valid = 1'b0;

    // Decoder stall: buffer held, no new fetch issued.
    inst_ready = 1'b0;
    step();
    step();
    chk_out("stall.cap", 1'b1, 32'h0820_0093, 32'h8000_0204, 1'b0, 1'b0, 32'h0);
    f0 = fire_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("stall%0d", i), 1'b1, 32'h0820_0093, 32'h8000_0204, 1'b0, 1'b0, 32'h0);
    end
    chk("stall.fires", fire_cnt, f0);
    inst_ready = 1'b1;
    step();
    chk_out("stall.adv", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0208);
    inst_ready = 1'b0;

    // Redirect while waiting on a slow response: stale word must be dropped.
    lat = 3;
    step();
    chk_out("drop.wait", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk_out("drop.redir", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out($sformatf("drop%0d", i), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    step();
    chk_out("drop.req", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0100);
    lat = 0;
    step();
    step();
    chk_out("drop.new", 1'b1, 32'h0410_0093, 32'h8000_0100, 1'b0, 1'b0, 32'h0);
    inst_ready = 1'b1;
    step();
    chk_out("drop.adv", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0104);
    inst_ready = 1'b0;

    // Misaligned redirect target, issued while the memory refuses requests.
    ready_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    f0 = fire_cnt;
`ifdef IFU_ALIGN_CHECK_EN
    chk_out("align.redir", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    ready_en = 1'b1;
    step();
    chk_out("align.fault", 1'b1, 32'h0000_0013, 32'h8000_0102, 1'b1, 1'b0, 32'h0);
    inst_ready = 1'b1;
    step();
    chk_out("align.halt0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk_out("align.halt1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("align.fires", fire_cnt, f0);
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0104;
    step();
    redirect_valid = 1'b0;
    chk_out("align.exit", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0104);
`else
    chk_out("align.redir", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0100);
    ready_en = 1'b1;
    step();
    step();
    chk_out("align.fetch", 1'b1, 32'h0410_0093, 32'h8000_0100, 1'b0, 1'b0, 32'h0);
    chk("align.fires", fire_cnt, f0 + 1);
    inst_ready = 1'b1;
    step();
    chk_out("align.adv", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0104);
    inst_ready = 1'b0;
`endif

    // Reset while a fetch is outstanding.
    lat = 5;
    step();
    chk_out("mrst.wait", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    step();
    chk("mrst.req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("mrst.inst", inst, 32'h0000_0013);
    chk("mrst.inst_pc", inst_pc, 32'h8000_0000);
    chk("mrst.inst_valid", {31'h0, inst_valid}, 32'h0);
    lat = 0;
    rst_n = 1'b1;
    #1;
    chk_out("mrst.rel", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0000);
    step();
    step();
    chk_out("mrst.fetch", 1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
